pll_ctrl: RTL and testbench

Parametrised sequencer for a vendor PLL primitive. It runs on the PLL reference clock and drives the PLL reset. It qualifies the asynchronous lock output and enables up to seven output clocks in a staggered order. It detects lock loss and either re-runs the lock sequence or parks in a fault state. The block sits next to each PLL wrapper (DDR, camera, HDMI) and feeds `enclk*`, `reset` and downstream domain-ready signals.

---
 rtl/pll_ctrl_pkg.sv | 24 ++
 rtl/pll_ctrl_sync_2ff.sv | 21 ++
 rtl/pll_ctrl.sv | 137 +++++++++++++
 tb/tb_pll_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default parameters for the PLL lock sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    ENABLE,
    RUN,
    FAULT
  } pll_ctrl_state_e;

  localparam int DEF_NUM_CLK      = 3;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_ENABLE_GAP   = 8;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_CNT_W        = 8;

  // Width needed to hold 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// PLL reset/lock sequencer with staggered output-clock enables.
// Optional PLL_CTRL_AUTO_RELOCK_EN: lock loss restarts the sequence instead of parking in FAULT.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_CLK      = DEF_NUM_CLK,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int ENABLE_GAP   = DEF_ENABLE_GAP,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic [NUM_CLK-1:0] enclk,
  output logic               ready,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   relock_cnt
);

  localparam int RST_W  = cnt_w(RST_CYCLES);
  localparam int STAB_W = cnt_w(LOCK_STABLE);
  localparam int TMO_W  = cnt_w(LOCK_TIMEOUT);
  localparam int EN_MAX = (NUM_CLK - 1) * ENABLE_GAP + 1;
  localparam int EN_W   = cnt_w(EN_MAX);

  pll_ctrl_state_e state;
  logic [RST_W-1:0]  rst_cnt;
  logic [STAB_W-1:0] stab_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [EN_W-1:0]   en_cnt;
  logic lock_s, seen_en;
  logic lock_lost, stab_hit, tmo_hit, restart, bump;

  sync_2ff u_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign lock_lost = !lock_s && (state == ENABLE || state == RUN);
  assign stab_hit  = (state == WAIT_LOCK) && lock_s &&
                     (stab_cnt == STAB_W'(LOCK_STABLE - 1));
  // A lock that completes on the timeout cycle wins over the timeout.
  assign tmo_hit   = (state == WAIT_LOCK) && !stab_hit &&
                     (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));

`ifdef PLL_CTRL_AUTO_RELOCK_EN
  assign restart = relock_req || tmo_hit || lock_lost;
  assign bump    = relock_req ? seen_en : lock_lost;
`else
  assign restart = relock_req || tmo_hit;
  assign bump    = relock_req && seen_en;
`endif

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= RST_PLL;
      pll_reset   <= 1'b1;
      enclk       <= '0;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
      relock_cnt  <= '0;
      rst_cnt     <= '0;
      stab_cnt    <= '0;
      tmo_cnt     <= '0;
      en_cnt      <= '0;
      seen_en     <= 1'b0;
    end else if (restart) begin
      state     <= RST_PLL;
      pll_reset <= 1'b1;
      enclk     <= '0;
      ready     <= 1'b0;
      rst_cnt   <= '0;
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      en_cnt    <= '0;
      if (tmo_hit && !relock_req) timeout_err <= 1'b1;
      if (bump && relock_cnt != '1) relock_cnt <= relock_cnt + 1'b1;
    end else begin
      case (state)
        RST_PLL: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            state     <= WAIT_LOCK;
            pll_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (stab_hit) begin
            state   <= ENABLE;
            seen_en <= 1'b1;
            en_cnt  <= '0;
          end else begin
            stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
        end
        ENABLE, RUN: begin
          // Only reachable without auto-relock; otherwise lock loss restarts.
          if (lock_lost) begin
            state     <= FAULT;
            pll_reset <= 1'b1;
            enclk     <= '0;
            ready     <= 1'b0;
          end else if (state == ENABLE) begin
            for (int i = 0; i < NUM_CLK; i++)
              if (en_cnt == EN_W'(i * ENABLE_GAP)) enclk[i] <= 1'b1;
            if (en_cnt == EN_W'(EN_MAX)) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              en_cnt <= en_cnt + 1'b1;
            end
          end
        end
        FAULT: begin
          pll_reset <= 1'b1;
          enclk     <= '0;
          ready     <= 1'b0;
        end
        default: begin
          state     <= RST_PLL;
          pll_reset <= 1'b1;
          enclk     <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// Self-checking bench for pll_ctrl: directed table, corner sequences, random lock traffic.
module tb_pll_ctrl;

  localparam int N    = 3;
  localparam int RSTC = 16;
  localparam int STAB = 64;
  localparam int GAP  = 8;
  localparam int TMO  = 128;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clkin = 1'b0, reset = 1'b1, pll_lock = 1'b0, relock_req = 1'b0;
  logic pll_reset, ready, timeout_err;
  logic [N-1:0] enclk;
  logic [CW-1:0] relock_cnt;

  int nvec = 0, nbad = 0;

  pll_ctrl #(
    .NUM_CLK(N), .RST_CYCLES(RSTC), .LOCK_STABLE(STAB),
    .ENABLE_GAP(GAP), .LOCK_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_reset(pll_reset), .enclk(enclk), .ready(ready),
    .timeout_err(timeout_err), .relock_cnt(relock_cnt)
  );

  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: phase 0 reset-hold, 1 waiting, 2 enabling, 3 running, 4 parked.
  // t = edges spent in the current phase, run = consecutive synchronised-lock edges.
  int ph, t, run, rc, cyc;
  bit seen, terr, lk1, lks;

  task automatic model_reset();
    ph = 0; t = 0; run = 0; rc = 0; cyc = 0;
    seen = 0; terr = 0; lk1 = 0; lks = 0;
  endtask

  task automatic model_step();
    bit lock_now;
    cyc++;
    lock_now = lks; lks = lk1; lk1 = pll_lock;
    if (relock_req) begin
      if (seen && rc < CMAX) rc++;
      ph = 0; t = 0;
    end else begin
      case (ph)
        0: begin
          t++;
          if (t == RSTC) begin ph = 1; t = 0; run = 0; end
        end
        1: begin
          t++;
          run = lock_now ? run + 1 : 0;
          if (run == STAB) begin ph = 2; t = 0; seen = 1; end
          else if (t == TMO) begin terr = 1; ph = 0; t = 0; end
        end
        2, 3: begin
          if (!lock_now) begin
`ifdef PLL_CTRL_AUTO_RELOCK_EN
            ph = 0; t = 0;
            if (rc < CMAX) rc++;
`else
            ph = 4;
`endif
          end else if (ph == 2) begin
            t++;
            if (t == (N - 1) * GAP + 2) ph = 3;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      if (nbad <= 20)
        $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) e[i] = (ph == 3) || (ph == 2 && t > i * GAP);
    chk({tag, ".pll_reset"}, 32'(pll_reset), 32'(ph == 0 || ph == 4));
    chk({tag, ".enclk"}, 32'(enclk), 32'(e));
    chk({tag, ".ready"}, 32'(ready), 32'(ph == 3));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(terr));
    chk({tag, ".relock_cnt"}, 32'(relock_cnt), rc);
  endtask

  task automatic step();
    @(posedge clkin);
    model_step();
    @(negedge clkin);
    compare_all("model");
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset(input bit lock);
    @(negedge clkin);
    reset = 1'b1; pll_lock = lock; relock_req = 1'b0;
    model_reset();
    @(negedge clkin);
    reset = 1'b0;
    compare_all("reset");
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
  endtask

  typedef struct {
    int           cyc;
    bit           lock;
    bit           prst;
    logic [N-1:0] en;
    bit           rdy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int c0;
    // Lock driven high from edge 20; lock_s usable from edge 22, so ENABLE at 85.
    tbl = '{
      '{0,   0, 1, 3'b000, 0}, '{15,  0, 1, 3'b000, 0}, '{16,  0, 0, 3'b000, 0},
      '{19,  0, 0, 3'b000, 0}, '{85,  1, 0, 3'b000, 0}, '{86,  1, 0, 3'b001, 0},
      '{93,  1, 0, 3'b001, 0}, '{94,  1, 0, 3'b011, 0}, '{101, 1, 0, 3'b011, 0},
      '{102, 1, 0, 3'b111, 0}, '{103, 1, 0, 3'b111, 1}, '{110, 1, 0, 3'b111, 1}
    };

    do_reset(1'b0);
    foreach (tbl[k]) begin
      pll_lock = tbl[k].lock;
      run_to(tbl[k].cyc);
      chk($sformatf("tbl%0d.pll_reset", k), 32'(pll_reset), 32'(tbl[k].prst));
      chk($sformatf("tbl%0d.enclk", k), 32'(enclk), 32'(tbl[k].en));
      chk($sformatf("tbl%0d.ready", k), 32'(ready), 32'(tbl[k].rdy));
    end

    // One-cycle lock glitch at stable count 40 restarts the 64-cycle qualification.
    do_reset(1'b1);
    run_to(54);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    run_to(81);
    chk("glitch.no_early_enable", 32'(enclk), 32'h0);
    run_to(121);
    chk("glitch.pre_enable", 32'(enclk), 32'h0);
    step();
    chk("glitch.enclk0", 32'(enclk), 32'h1);

    // No lock: timeout after 128 waiting cycles, reset re-pulses for 16.
    do_reset(1'b0);
    run_to(143);
    chk("tmo.err_before", 32'(timeout_err), 32'h0);
    chk("tmo.prst_before", 32'(pll_reset), 32'h0);
    step();
    chk("tmo.err", 32'(timeout_err), 32'h1);
    chk("tmo.prst", 32'(pll_reset), 32'h1);
    run_to(159);
    chk("tmo.prst_hold", 32'(pll_reset), 32'h1);
    step();
    chk("tmo.prst_release", 32'(pll_reset), 32'h0);
    chk("tmo.relock_cnt", 32'(relock_cnt), 32'h0);
    pulse_relock();
    chk("tmo.req_before_enable", 32'(relock_cnt), 32'h0);
    chk("tmo.err_sticky", 32'(timeout_err), 32'h1);

    // Lock lost while running.
    do_reset(1'b1);
    run_to(98);
    chk("drop.ready", 32'(ready), 32'h1);
    run_to(100);
    pll_lock = 1'b0;
    run_to(102);
    chk("drop.enclk_before", 32'(enclk), 32'h7);
    step();
    chk("drop.enclk", 32'(enclk), 32'h0);
    chk("drop.ready_low", 32'(ready), 32'h0);
    chk("drop.prst", 32'(pll_reset), 32'h1);
    pll_lock = 1'b1;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
    chk("drop.relock_cnt", 32'(relock_cnt), 32'h1);
    run_to(200);
    chk("drop.ready_not_yet", 32'(ready), 32'h0);
    step();
    chk("drop.ready_again", 32'(ready), 32'h1);
`else
    chk("drop.relock_cnt", 32'(relock_cnt), 32'h0);
    run_to(150);
    chk("fault.prst", 32'(pll_reset), 32'h1);
    chk("fault.enclk", 32'(enclk), 32'h0);
    pulse_relock();
    chk("fault.relock_cnt", 32'(relock_cnt), 32'h1);
    run_to(248);
    chk("fault.ready_not_yet", 32'(ready), 32'h0);
    step();
    chk("fault.ready_again", 32'(ready), 32'h1);
`endif

    // relock_req coincident with lock loss: exactly one restart, no FAULT.
    c0 = cyc;
    pll_lock = 1'b0;
    step();
    step();
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    pll_lock = 1'b1;
    chk("both.relock_cnt", 32'(relock_cnt), 32'h2);
    chk("both.prst", 32'(pll_reset), 32'h1);
    run_to(c0 + 18);
    chk("both.prst_hold", 32'(pll_reset), 32'h1);
    step();
    chk("both.prst_release", 32'(pll_reset), 32'h0);

    // Five more restarts saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      pulse_relock();
      step();
      chk($sformatf("sat%0d.relock_cnt", k), 32'(relock_cnt), (k + 3 > CMAX) ? CMAX : k + 3);
    end

    // Asynchronous reset in the middle of ENABLE.
    do_reset(1'b1);
    run_to(89);
    chk("async.enclk_mid", 32'(enclk), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("async.prst", 32'(pll_reset), 32'h1);
    chk("async.enclk", 32'(enclk), 32'h0);
    chk("async.ready", 32'(ready), 32'h0);
    chk("async.relock_cnt", 32'(relock_cnt), 32'h0);
    model_reset();
    @(negedge clkin);
    reset = 1'b0;
    compare_all("async_release");

    // Random lock traffic with occasional restart requests.
    do_reset(1'b1);
    for (int b = 0; b < 30; b++) begin
      int hi, lo;
      hi = $urandom_range(300, 40);
      lo = ($urandom_range(4, 0) == 0) ? $urandom_range(250, 150) : $urandom_range(20, 1);
      pll_lock = 1'b1;
      for (int i = 0; i < hi; i++) begin
        relock_req = ($urandom_range(199, 0) == 0);
        step();
      end
      relock_req = 1'b0;
      pll_lock = 1'b0;
      for (int i = 0; i < lo; i++) begin
        relock_req = ($urandom_range(199, 0) == 0);
        step();
      end
      relock_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
